// File: rtl/data_bus_reg_slave.sv
// data_bus_reg_slave
// Responder end of the SoC data bus. Serves req/gnt/rvalid transactions from a
// bank of 32-bit read/write registers. Optional wait states can be inserted
// before the grant. The register contents and one-hot write strobes are
// exported to the peripheral core.
module data_bus_reg_slave #(
   parameter int NUM_REGS    = 8,
   parameter int WAIT_STATES = 0,
   parameter int IDX_LSB     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req,
   input  logic [31:0]              addr,
   input  logic                     we,
   input  logic [3:0]               be,
   input  logic [31:0]              wdata,
   output logic                     gnt,
   output logic                     rvalid,
   output logic [31:0]              rdata,
   output logic                     err,
   output logic [NUM_REGS*32-1:0]   reg_q,
   output logic [NUM_REGS-1:0]      wr_pulse
);

   // One extra index bit beyond what NUM_REGS needs, so that addresses just
   // past the bank decode as out of range instead of aliasing onto it.
   localparam int              IDX_W     = $clog2(NUM_REGS) + 1;
   localparam logic [IDX_W-1:0] NUM_REGS_C = IDX_W'(NUM_REGS);
   localparam logic [3:0]      WS_C      = 4'(WAIT_STATES);
   localparam bit              WS_ZERO   = (WAIT_STATES == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Expand the 4 byte enables to a 32-bit bit mask.
   function automatic logic [31:0] be_to_mask(input logic [3:0] b);
      logic [31:0] m;
      m = 32'd0;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{b[i]}};
      end
      return m;
   endfunction

   state_t               state_r;
   state_t               state_nxt_s;
   logic [3:0]           cnt_r;
   logic [3:0]           cnt_nxt_s;
   logic                 gnt_s;

   logic [IDX_W-1:0]     idx_s;
   logic                 in_range_s;
   logic [NUM_REGS-1:0]  sel_s;
   logic [NUM_REGS-1:0]  wsel_s;
   logic [31:0]          rd_data_s;
   logic [31:0]          wmask_s;

   logic [31:0]          reg_r [NUM_REGS];
   logic                 rvalid_r;
   logic [31:0]          rdata_r;
   logic                 err_r;
   logic [NUM_REGS-1:0]  wr_pulse_r;

   // Only the index field of the address is decoded. The remaining bits are
   // intentionally ignored, and folding them here keeps that explicit.
   logic                 unused_addr_s;
   assign unused_addr_s = ^addr;

   assign idx_s      = addr[IDX_LSB +: IDX_W];
   assign in_range_s = (idx_s < NUM_REGS_C);
   assign wmask_s    = be_to_mask(be);

   // State and wait-counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state, wait counting and grant decision.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      gnt_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req) begin
               if (WS_ZERO) begin
                  gnt_s       = 1'b1;
                  state_nxt_s = ST_RESP;
               end else begin
                  cnt_nxt_s   = 4'd1;
                  state_nxt_s = ST_WAIT;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               // Requester gave up: abort without touching the bank.
               cnt_nxt_s   = 4'd0;
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == WS_C) begin
               gnt_s       = 1'b1;
               cnt_nxt_s   = 4'd0;
               state_nxt_s = ST_RESP;
            end else begin
               cnt_nxt_s   = cnt_r + 4'd1;
            end
         end
         ST_RESP: begin
            // Response cycle: never grant here, so grants cannot be back-to-back.
            state_nxt_s = ST_IDLE;
         end
         default: begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign gnt = gnt_s;

   // Register selects and read multiplexer. This stays empty when out of range.
   always_comb begin
      sel_s     = '0;
      wsel_s    = '0;
      rd_data_s = 32'd0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (in_range_s && (idx_s == IDX_W'(k))) begin
            sel_s[k]  = 1'b1;
            wsel_s[k] = gnt_s & we;
            rd_data_s = reg_r[k];
         end else begin
            sel_s[k]  = 1'b0;
            wsel_s[k] = 1'b0;
         end
      end
   end

   // Register bank: byte-masked update on a granted in-range write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            reg_r[k] <= 32'd0;
         end
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (wsel_s[k]) begin
               reg_r[k] <= (reg_r[k] & ~wmask_s) | (wdata & wmask_s);
            end
         end
      end
   end

   // Response registers: these are loaded at the grant edge and are zero on every other cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_r   <= 1'b0;
         rdata_r    <= 32'd0;
         err_r      <= 1'b0;
         wr_pulse_r <= '0;
      end else begin
         rvalid_r   <= gnt_s;
         rdata_r    <= (gnt_s && !we) ? rd_data_s : 32'd0;
         err_r      <= gnt_s & ~in_range_s;
         wr_pulse_r <= wsel_s;
      end
   end

   // Drive the flattened register contents to the peripheral core.
   always_comb begin
      reg_q = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         reg_q[32*k +: 32] = reg_r[k];
      end
   end

   assign rvalid   = rvalid_r;
   assign rdata    = rdata_r;
   assign err      = err_r;
   assign wr_pulse = wr_pulse_r;

endmodule
